// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter: two-client round-robin owner of one SD controller (issue, busy handshake, release).
// Optional per-phase busy timeout (done with err=1) is compiled in with `define SD_ARB_TIMEOUT_EN.
module sd_sector_arbiter #(
  parameter int unsigned BUSY_TIMEOUT = 50_000_000
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        init_end,
  input  logic        req0,
  input  logic        req1,
  input  logic        req0_wr,
  input  logic        req1_wr,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req1_addr,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic        sd_wr_en,
  output logic        sd_rd_en,
  output logic [31:0] sd_wr_addr,
  output logic [31:0] sd_rd_addr,
  input  logic        sd_wr_busy,
  input  logic        sd_rd_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;

  state_t      state, state_nxt;
  logic        owner;
  logic        last;
  logic        lat_wr;
  logic [31:0] lat_addr;
  logic        grant;
  logic        winner;
  logic        sel_busy;
  logic        to_hit;

  assign grant    = (state == IDLE) && init_end && (req0 || req1);
  // Contention goes to whoever was not served last; otherwise the lone requester.
  assign winner   = (req0 && req1) ? ~last : (req1 && !req0);
  assign sel_busy = lat_wr ? sd_wr_busy : sd_rd_busy;

`ifdef SD_ARB_TIMEOUT_EN
  logic [31:0] cnt;
  logic        to_err;
  logic        err_q;

  assign to_hit = (cnt == BUSY_TIMEOUT - 1);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
      cnt <= cnt + 32'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_nxt == RELEASE && state != RELEASE) begin
      err_q <= to_err;
    end
  end

  assign err = (state == RELEASE) && err_q;
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
`ifdef SD_ARB_TIMEOUT_EN
    to_err    = 1'b0;
`endif
    case (state)
      IDLE:      if (grant) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (sel_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_hit) begin
          state_nxt = RELEASE;
`ifdef SD_ARB_TIMEOUT_EN
          to_err    = 1'b1;
`endif
        end
      end
      WAIT_DONE: begin
        if (!sel_busy) begin
          state_nxt = RELEASE;
        end else if (to_hit) begin
          state_nxt = RELEASE;
`ifdef SD_ARB_TIMEOUT_EN
          to_err    = 1'b1;
`endif
        end
      end
      RELEASE:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner    <= winner;
        last     <= winner;
        lat_wr   <= winner ? req1_wr : req0_wr;
        lat_addr <= winner ? req1_addr : req0_addr;
      end
    end
  end

  assign gnt0       = (state != IDLE) && !owner;
  assign gnt1       = (state != IDLE) && owner;
  assign done0      = (state == RELEASE) && !owner;
  assign done1      = (state == RELEASE) && owner;
  assign sd_wr_en   = (state == ISSUE) && lat_wr;
  assign sd_rd_en   = (state == ISSUE) && !lat_wr;
  assign sd_wr_addr = lat_addr;
  assign sd_rd_addr = lat_addr;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter: expected operations queued at request time, checked at issue and done.
module tb_sd_sector_arbiter;

  localparam int unsigned TO = 64;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_end = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, req0_wr = 1'b0, req1_wr = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic        gnt0, gnt1, done0, done1, err, sd_wr_en, sd_rd_en;
  logic [31:0] sd_wr_addr, sd_rd_addr;
  logic        sd_wr_busy, sd_rd_busy;
  logic        mb_wr = 1'b0, mb_rd = 1'b0, noise_rd = 1'b0;
  bit          sd_live = 1'b1;
  int          busy_len = 20;
  int          cyc = 0, fall_cyc = 0, issue_cyc = 0, done_cnt = 0;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    bit          client;
    bit          wr;
    logic [31:0] addr;
    bit          err;
  } exp_t;
  exp_t exp_q[$];

  assign sd_wr_busy = mb_wr;
  assign sd_rd_busy = mb_rd | noise_rd;

  sd_sector_arbiter #(.BUSY_TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .reset(reset), .init_end(init_end),
    .req0(req0), .req1(req1), .req0_wr(req0_wr), .req1_wr(req1_wr),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .sd_wr_en(sd_wr_en), .sd_rd_en(sd_rd_en),
    .sd_wr_addr(sd_wr_addr), .sd_rd_addr(sd_rd_addr),
    .sd_wr_busy(sd_wr_busy), .sd_rd_busy(sd_rd_busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input bit c, input bit w, input logic [31:0] a, input bit e);
    exp_t x;
    x.client = c; x.wr = w; x.addr = a; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic set_req(input bit c, input bit w, input logic [31:0] a);
    if (c) begin req1 = 1'b1; req1_wr = w; req1_addr = a; end
    else   begin req0 = 1'b1; req0_wr = w; req0_addr = a; end
  endtask

  task automatic raise(input bit c, input bit w, input logic [31:0] a);
    set_req(c, w, a);
    push(c, w, a, 1'b0);
  endtask

  task automatic drop(input bit c);
    if (c) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int b = 0;
    while (done_cnt < target && b < 1000) begin @(posedge sys_clk); b++; end
    #1;
    if (done_cnt < target) check({tag, "_no_done"}, done_cnt, target);
  endtask

  task automatic run_one(input bit c, input bit w, input logic [31:0] a, input string tag);
    int t;
    t = done_cnt + 1;
    raise(c, w, a);
    wait_done(t, tag);
    drop(c);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b0;
  endtask

  // SD controller model: raise the issued direction's busy after the start pulse, hold busy_len cycles.
  initial begin
    forever begin
      @(negedge sys_clk);
      if ((sd_wr_en || sd_rd_en) && sd_live) begin
        bit w;
        w = sd_wr_en;
        @(posedge sys_clk); #1;
        if (w) mb_wr = 1'b1; else mb_rd = 1'b1;
        repeat (busy_len) @(posedge sys_clk);
        #1;
        mb_wr = 1'b0; mb_rd = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  // Scoreboard: front entry checked at the start pulse, popped at the done pulse.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (sd_wr_en || sd_rd_en) begin
        issue_cyc = cyc;
        if (exp_q.size() == 0) check("issue_unexpected", 1, 0);
        else begin
          check("issue_single_en", sd_wr_en & sd_rd_en, 0);
          check("issue_gnt", {gnt1, gnt0}, exp_q[0].client ? 2'b10 : 2'b01);
          check("issue_dir", sd_wr_en, exp_q[0].wr);
          check("issue_addr", exp_q[0].wr ? sd_wr_addr : sd_rd_addr, exp_q[0].addr);
        end
      end
      if (done0 || done1) begin
        if (exp_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_client", {done1, done0}, e.client ? 2'b10 : 2'b01);
          check("done_err", err, e.err);
          if (e.err) check("timeout_latency", cyc - issue_cyc, TO + 1);
          else       check("done_latency", cyc - fall_cyc, 1);
        end
        done_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit bad, bad2;
    int b, d;
    #2;
    check("rst_gnt0", gnt0, 0);      check("rst_gnt1", gnt1, 0);
    check("rst_done0", done0, 0);    check("rst_done1", done1, 0);
    check("rst_err", err, 0);        check("rst_wr_en", sd_wr_en, 0);
    check("rst_rd_en", sd_rd_en, 0); check("rst_wr_addr", sd_wr_addr, 0);
    check("rst_rd_addr", sd_rd_addr, 0);
    @(posedge sys_clk); #1 reset = 1'b0;

    // Single read.
    init_end = 1'b1;
    d = done_cnt;
    raise(1'b0, 1'b0, 32'h0000_1000);
    @(posedge sys_clk); #1;
    check("rd_gnt0", gnt0, 1);
    check("rd_en", sd_rd_en, 1);
    check("rd_addr", sd_rd_addr, 32'h0000_1000);
    @(posedge sys_clk); #1;
    check("rd_en_one_cycle", sd_rd_en, 0);
    check("rd_gnt_held", gnt0, 1);
    wait_done(d + 1, "single_read");
    drop(1'b0);

    // Contention out of reset: client 0 first, then client 1.
    pulse_reset();
    set_req(1'b0, 1'b0, 32'h0000_0010);
    set_req(1'b1, 1'b1, 32'h0000_0020);
    push(1'b0, 1'b0, 32'h0000_0010, 1'b0);
    push(1'b1, 1'b1, 32'h0000_0020, 1'b0);
    d = done_cnt;
    wait_done(d + 1, "rr_first");
    drop(1'b0);
    wait_done(d + 2, "rr_second");
    drop(1'b1);
    // A solo client-0 operation leaves client 0 as last served, so the next tie goes to client 1.
    run_one(1'b0, 1'b1, 32'h0000_0030, "solo0");
    set_req(1'b0, 1'b1, 32'h0000_0040);
    set_req(1'b1, 1'b0, 32'h0000_0050);
    push(1'b1, 1'b0, 32'h0000_0050, 1'b0);
    push(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    d = done_cnt;
    wait_done(d + 1, "rr_swap_first");
    drop(1'b1);
    wait_done(d + 2, "rr_swap_second");
    drop(1'b0);

    // Gated start, then init_end falls mid-operation.
    init_end = 1'b0;
    set_req(1'b1, 1'b1, 32'h0000_0777);
    bad = 1'b0;
    repeat (100) begin
      @(posedge sys_clk); #1;
      if (gnt0 | gnt1 | sd_wr_en | sd_rd_en) bad = 1'b1;
    end
    check("gated_no_grant", bad, 0);
    push(1'b1, 1'b1, 32'h0000_0777, 1'b0);
    d = done_cnt;
    init_end = 1'b1;
    b = 0;
    while (!gnt1 && b < 2) begin @(posedge sys_clk); #1; b++; end
    check("gated_grant_latency", gnt1, 1);
    init_end = 1'b0;
    wait_done(d + 1, "init_drop");
    drop(1'b1);
    init_end = 1'b1;

    // Reset during WAIT_DONE.
    d = done_cnt;
    raise(1'b0, 1'b1, 32'h0000_ABCD);
    b = 0;
    while (!sd_wr_busy && b < 50) begin @(posedge sys_clk); #1; b++; end
    check("rst_mid_busy_seen", sd_wr_busy, 1);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b1;
    #1;
    check("rst_mid_gnt0", gnt0, 0);       check("rst_mid_wr_en", sd_wr_en, 0);
    check("rst_mid_done0", done0, 0);     check("rst_mid_err", err, 0);
    check("rst_mid_wr_addr", sd_wr_addr, 0);
    check("rst_mid_rd_addr", sd_rd_addr, 0);
    exp_q.delete();
    drop(1'b0);
    repeat (30) @(posedge sys_clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge sys_clk);
    #1;
    check("rst_mid_no_done", done_cnt, d);
    run_one(1'b0, 1'b0, 32'h0000_2222, "after_reset");

    // Owner changes addr mid-op while client 1 waits; the idle read busy flag is held high throughout.
    noise_rd = 1'b1;
    d = done_cnt;
    raise(1'b0, 1'b1, 32'h0000_5000);
    b = 0;
    while (!sd_wr_busy && b < 50) begin @(posedge sys_clk); #1; b++; end
    repeat (3) @(posedge sys_clk);
    #1;
    req0_addr = 32'h0000_6000;
    raise(1'b1, 1'b0, 32'h0000_7000);
    bad = 1'b0; bad2 = 1'b0; b = 0;
    while (done_cnt < d + 1 && b < 200) begin
      @(posedge sys_clk); #1; b++;
      if (sd_wr_addr !== 32'h0000_5000) bad = 1'b1;
      if (gnt1) bad2 = 1'b1;
    end
    check("midop_addr_hold", bad, 0);
    check("midop_no_gnt1", bad2, 0);
    check("midop_done", done_cnt, d + 1);
    check("release_gnt1_low", gnt1, 0);
    noise_rd = 1'b0;
    drop(1'b0);
    wait_done(d + 2, "after_midop");
    drop(1'b1);

    // Write with the controller never going busy.
    sd_live = 1'b0;
    d = done_cnt;
    set_req(1'b0, 1'b1, 32'h0000_9000);
`ifdef SD_ARB_TIMEOUT_EN
    push(1'b0, 1'b1, 32'h0000_9000, 1'b1);
    wait_done(d + 1, "timeout");
    drop(1'b0);
`else
    push(1'b0, 1'b1, 32'h0000_9000, 1'b0);
    bad = 1'b0;
    repeat (200) begin
      @(posedge sys_clk); #1;
      if (err) bad = 1'b1;
    end
    check("no_timeout_done", done_cnt, d);
    check("no_timeout_err", bad, 0);
    check("no_timeout_gnt_held", gnt0, 1);
    pulse_reset();
    exp_q.delete();
    drop(1'b0);
`endif
    sd_live = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
